c7bifu_iq_mw: RTL and testbench

Parametrised multi-word instruction queue for the c7bifu fetch path. It accepts fetch beats of FETCH_WORDS 32-bit instructions and drops stale beats after a redirect. On an unaligned start address it discards leading words, and presents up to ISSUE_WIDTH in-order instructions per cycle to decode. The head is shown ahead, so outputs come straight from the queue head, and decode consumes a variable count.

---
 rtl/c7bifu_iq_mw.sv | 117 +++++++++++
 tb/tb_c7bifu_iq_mw.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c7bifu_iq_mw.sv
// c7bifu_iq_mw: multi-word fetch instruction queue with redirect filtering,
// unaligned-start word skipping and a show-ahead multi-lane issue port.
module c7bifu_iq_mw #(
  parameter int unsigned FETCH_WORDS = 2,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned ISSUE_WIDTH = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               flush,
  input  logic [31:0]                        start_addr,
  input  logic [31:0]                        data_addr,
  input  logic [32*FETCH_WORDS-1:0]          data,
  input  logic                               data_vld,
  output logic                               iq_full,
  output logic [$clog2(DEPTH):0]             free_cnt,
  output logic [ISSUE_WIDTH-1:0]             inst_vld,
  output logic [32*ISSUE_WIDTH-1:0]          inst_addr,
  output logic [32*ISSUE_WIDTH-1:0]          inst,
  input  logic [$clog2(ISSUE_WIDTH+1)-1:0]   inst_acc
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned PtrW = IdxW + 1;
  localparam int unsigned SkW  = $clog2(FETCH_WORDS) + 1;
  localparam int unsigned OffW = $clog2(FETCH_WORDS) + 2;
  localparam logic [31:0] OffMask = 32'((1 << OffW) - 1);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]     exp_addr_q, exp_addr_d;
  logic [SkW-1:0]  skip_q, skip_d;
  logic [31:0]     mem_q [DEPTH];
  logic [31:0]     mem_d [DEPTH];
  logic [31:0]     addr_q [DEPTH];
  logic [31:0]     addr_d [DEPTH];

  logic [PtrW-1:0] count;
  logic [PtrW-1:0] nvld;
  logic            accept;
  logic [IdxW-1:0] widx;

  // Occupancy and flow control come from registered pointers only.
  assign count    = wr_ptr_q - rd_ptr_q;
  assign free_cnt = PtrW'(DEPTH) - count;
  assign iq_full  = free_cnt < PtrW'(FETCH_WORDS);
  assign accept   = data_vld && !iq_full && !flush;
  assign nvld     = (count > PtrW'(ISSUE_WIDTH)) ? PtrW'(ISSUE_WIDTH) : count;

  // Next state: flush redirect, consumption, and filtered beat write.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    exp_addr_d = exp_addr_q;
    skip_d     = skip_q;
    mem_d      = mem_q;
    addr_d     = addr_q;
    widx       = '0;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      exp_addr_d = start_addr & ~OffMask;
      skip_d     = SkW'((start_addr >> 2) & 32'(FETCH_WORDS - 1));
    end else begin
      rd_ptr_d = rd_ptr_q + PtrW'(inst_acc);
      // Beats not at the expected address are leftovers from before a redirect.
      if (accept && (data_addr == exp_addr_q)) begin
        for (int unsigned k = 0; k < FETCH_WORDS; k++) begin
          if (SkW'(k) >= skip_q) begin
            widx         = IdxW'(wr_ptr_q + PtrW'(k) - PtrW'(skip_q));
            mem_d[widx]  = data[32*k +: 32];
            addr_d[widx] = data_addr + 32'(4 * k);
          end
        end
        wr_ptr_d   = wr_ptr_q + PtrW'(FETCH_WORDS) - PtrW'(skip_q);
        exp_addr_d = exp_addr_q + 32'(4 * FETCH_WORDS);
        skip_d     = '0;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      exp_addr_q <= '0;
      skip_q     <= '0;
      mem_q      <= '{default: '0};
      addr_q     <= '{default: '0};
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      exp_addr_q <= exp_addr_d;
      skip_q     <= skip_d;
      mem_q      <= mem_d;
      addr_q     <= addr_d;
    end
  end

  // Decode may only consume lanes that are currently shown as valid.
  always_ff @(posedge clk) begin
    if (!reset && !flush) begin
      assert (PtrW'(inst_acc) <= nvld);
    end
  end

  // Show-ahead lanes read straight from the head of the queue.
  for (genvar j = 0; j < ISSUE_WIDTH; j++) begin : g_lane
    logic [IdxW-1:0] lidx;
    assign lidx                 = IdxW'(rd_ptr_q + PtrW'(j));
    assign inst_vld[j]          = count > PtrW'(j);
    assign inst[32*j +: 32]      = mem_q[lidx];
    assign inst_addr[32*j +: 32] = addr_q[lidx];
  end

endmodule

// File: tb/tb_c7bifu_iq_mw.sv
// Testbench for c7bifu_iq_mw: directed scenarios plus random traffic, checked
// against a queue-based reference model.
module tb_c7bifu_iq_mw;

  localparam int FW = 2;
  localparam int DEPTH = 8;
  localparam int IW = 2;

  logic        clk = 1'b0;
  logic        reset, flush, data_vld;
  logic [31:0] start_addr, data_addr;
  logic [63:0] data;
  logic        iq_full;
  logic [3:0]  free_cnt;
  logic [1:0]  inst_vld;
  logic [63:0] inst_addr, inst;
  logic [1:0]  inst_acc;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of {addr, inst}, next expected beat address, skip count.
  logic [63:0] m_q[$];
  logic [31:0] m_exp;
  int          m_skip;

  always #5 clk = ~clk;

  c7bifu_iq_mw #(.FETCH_WORDS(FW), .DEPTH(DEPTH), .ISSUE_WIDTH(IW)) dut (
    .clk(clk), .reset(reset), .flush(flush), .start_addr(start_addr),
    .data_addr(data_addr), .data(data), .data_vld(data_vld), .iq_full(iq_full),
    .free_cnt(free_cnt), .inst_vld(inst_vld), .inst_addr(inst_addr), .inst(inst),
    .inst_acc(inst_acc)
  );

  task automatic set_idle();
    reset = 0; flush = 0; data_vld = 0; start_addr = '0; data_addr = '0; data = '0;
    inst_acc = '0;
  endtask

  // Apply the current inputs for one clock, advancing the model alongside.
  task automatic cycle();
    int acc_n;
    bit full;
    acc_n = int'(inst_acc);
    full  = (DEPTH - m_q.size()) < FW;
    if (reset) begin
      m_q.delete(); m_exp = '0; m_skip = 0;
    end else if (flush) begin
      m_q.delete();
      m_exp  = start_addr & ~32'(FW * 4 - 1);
      m_skip = int'((start_addr >> 2) % FW);
    end else begin
      repeat (acc_n) void'(m_q.pop_front());
      if (data_vld && !full && data_addr == m_exp) begin
        for (int k = m_skip; k < FW; k++) m_q.push_back({data_addr + 32'(4 * k), data[32*k +: 32]});
        m_exp  = m_exp + 32'(4 * FW);
        m_skip = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic beat(input logic [31:0] a, input logic [63:0] d);
    data_vld = 1; data_addr = a; data = d;
  endtask

  function automatic logic [134:0] model_obs();
    logic [1:0]  v;
    logic [63:0] a, i;
    int          fr;
    v = '0; a = '0; i = '0;
    for (int j = 0; j < IW; j++) begin
      if (j < m_q.size()) begin
        v[j] = 1'b1; a[32*j +: 32] = m_q[j][63:32]; i[32*j +: 32] = m_q[j][31:0];
      end
    end
    fr = DEPTH - m_q.size();
    return {fr < FW, 4'(fr), v, a, i};
  endfunction

  function automatic logic [134:0] dut_obs();
    logic [63:0] a, i;
    a = '0; i = '0;
    for (int j = 0; j < IW; j++) begin
      if (inst_vld[j] === 1'b1) begin
        a[32*j +: 32] = inst_addr[32*j +: 32]; i[32*j +: 32] = inst[32*j +: 32];
      end
    end
    return {iq_full, free_cnt, inst_vld, a, i};
  endfunction

  function automatic int model_acc_max();
    return (m_q.size() < IW) ? m_q.size() : IW;
  endfunction

  task automatic test_reset();
    set_idle(); reset = 1; cycle(); reset = 0;
    checks++;
    if (inst_vld !== 2'b00) begin errors++; $display("FAIL reset_vld got=%b exp=00", inst_vld); end
    checks++;
    if (free_cnt !== 4'd8) begin errors++; $display("FAIL reset_free got=%0d exp=8", free_cnt); end
    checks++;
    if (iq_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", iq_full); end
  endtask

  task automatic test_fill_drain();
    logic [31:0] a0, a1, b0, b1;
    a0 = $urandom; a1 = $urandom; b0 = $urandom; b1 = $urandom;
    set_idle(); flush = 1; start_addr = 32'h1000; cycle(); flush = 0;
    beat(32'h1000, {a1, a0}); cycle();
    beat(32'h1008, {b1, b0}); cycle(); data_vld = 0;
    checks++;
    if (inst_vld !== 2'b11) begin errors++; $display("FAIL fill_vld got=%b exp=11", inst_vld); end
    checks++;
    if (inst_addr !== 64'h0000_1004_0000_1000 || inst !== {a1, a0}) begin
      errors++; $display("FAIL fill_lanes got=%h/%h exp=%h/%h", inst_addr, inst,
                         64'h0000_1004_0000_1000, {a1, a0});
    end
    checks++;
    if (free_cnt !== 4'd4) begin errors++; $display("FAIL fill_free got=%0d exp=4", free_cnt); end
    inst_acc = 2; cycle();
    checks++;
    if (inst_addr !== 64'h0000_100c_0000_1008 || inst !== {b1, b0}) begin
      errors++; $display("FAIL drain_lanes got=%h/%h exp=%h/%h", inst_addr, inst,
                         64'h0000_100c_0000_1008, {b1, b0});
    end
    cycle(); inst_acc = 0;
    checks++;
    if (inst_vld !== 2'b00) begin errors++; $display("FAIL drain_empty got=%b exp=00", inst_vld); end
  endtask

  task automatic test_unaligned();
    logic [31:0] x, y;
    x = $urandom; y = $urandom;
    set_idle(); flush = 1; start_addr = 32'h2004; cycle(); flush = 0;
    beat(32'h2000, {y, x}); cycle(); data_vld = 0;
    checks++;
    if (free_cnt !== 4'd7 || inst_vld !== 2'b01) begin
      errors++; $display("FAIL unal_count got=%0d/%b exp=7/01", free_cnt, inst_vld);
    end
    checks++;
    if (inst_addr[31:0] !== 32'h2004 || inst[31:0] !== y) begin
      errors++; $display("FAIL unal_lane0 got=%h/%h exp=00002004/%h", inst_addr[31:0], inst[31:0], y);
    end
    beat(32'h2008, {$urandom, $urandom}); cycle(); data_vld = 0;
    checks++;
    if (free_cnt !== 4'd5 || dut_obs() !== model_obs()) begin
      errors++; $display("FAIL unal_next got=%0d/%h exp=5/%h", free_cnt, dut_obs(), model_obs());
    end
    inst_acc = 2; cycle(); inst_acc = 1; cycle(); inst_acc = 0;
    checks++;
    if (inst_vld !== 2'b00) begin errors++; $display("FAIL unal_drain got=%b exp=00", inst_vld); end
  endtask

  task automatic test_stale();
    set_idle(); flush = 1; start_addr = 32'h3000; cycle(); flush = 0;
    beat(32'h5000, {$urandom, $urandom}); cycle();
    checks++;
    if (free_cnt !== 4'd8 || inst_vld !== 2'b00) begin
      errors++; $display("FAIL stale_drop got=%0d/%b exp=8/00", free_cnt, inst_vld);
    end
    beat(32'h3000, {$urandom, $urandom}); cycle(); data_vld = 0;
    checks++;
    if (free_cnt !== 4'd6 || inst_addr[31:0] !== 32'h3000) begin
      errors++; $display("FAIL stale_next got=%0d/%h exp=6/00003000", free_cnt, inst_addr[31:0]);
    end
    inst_acc = 2; cycle(); inst_acc = 0;
  endtask

  task automatic test_full_wrap();
    set_idle(); flush = 1; start_addr = 32'h4004; cycle(); flush = 0;
    for (int b = 0; b < 4; b++) begin beat(32'h4000 + 32'(8 * b), {$urandom, $urandom}); cycle(); end
    checks++;
    if (iq_full !== 1'b1 || free_cnt !== 4'd1) begin
      errors++; $display("FAIL full_set got=%b/%0d exp=1/1", iq_full, free_cnt);
    end
    beat(32'h4020, {$urandom, $urandom}); cycle();
    checks++;
    if (iq_full !== 1'b1 || free_cnt !== 4'd1) begin
      errors++; $display("FAIL full_hold got=%b/%0d exp=1/1", iq_full, free_cnt);
    end
    inst_acc = 1; cycle(); inst_acc = 0;
    checks++;
    if (iq_full !== 1'b0 || free_cnt !== 4'd2) begin
      errors++; $display("FAIL full_release got=%b/%0d exp=0/2", iq_full, free_cnt);
    end
    cycle(); data_vld = 0;
    checks++;
    if (free_cnt !== 4'd0 || dut_obs() !== model_obs()) begin
      errors++; $display("FAIL full_accept got=%0d/%h exp=0/%h", free_cnt, dut_obs(), model_obs());
    end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (inst_addr[63:32] !== inst_addr[31:0] + 32'd4 || dut_obs() !== model_obs()) begin
        errors++; $display("FAIL wrap_lanes got=%h exp=%h", dut_obs(), model_obs());
      end
      inst_acc = 2; cycle();
    end
    inst_acc = 0;
  endtask

  task automatic test_simultaneous();
    set_idle(); flush = 1; start_addr = 32'h7000; cycle(); flush = 0;
    beat(32'h7000, {$urandom, $urandom}); cycle();
    beat(32'h7008, {$urandom, $urandom}); cycle();
    flush = 1; start_addr = 32'h9008; beat(32'h7010, {$urandom, $urandom}); inst_acc = 2;
    cycle(); flush = 0; inst_acc = 0; data_vld = 0;
    checks++;
    if (inst_vld !== 2'b00 || free_cnt !== 4'd8) begin
      errors++; $display("FAIL flush_wins got=%b/%0d exp=00/8", inst_vld, free_cnt);
    end
    beat(32'h9008, {$urandom, $urandom}); cycle(); data_vld = 0;
    checks++;
    if (free_cnt !== 4'd6 || inst_addr[31:0] !== 32'h9008) begin
      errors++; $display("FAIL flush_target got=%0d/%h exp=6/00009008", free_cnt, inst_addr[31:0]);
    end
    flush = 1; start_addr = 32'h6004; cycle(); flush = 0;
    for (int b = 0; b < 3; b++) begin beat(32'h6000 + 32'(8 * b), {$urandom, $urandom}); cycle(); end
    checks++;
    if (free_cnt !== 4'd3) begin errors++; $display("FAIL pre_reset got=%0d exp=3", free_cnt); end
    reset = 1; beat(32'h6018, {$urandom, $urandom}); inst_acc = 2; cycle();
    reset = 0; data_vld = 0; inst_acc = 0;
    checks++;
    if (inst_vld !== 2'b00 || free_cnt !== 4'd8 || iq_full !== 1'b0) begin
      errors++; $display("FAIL mid_reset got=%b/%0d/%b exp=00/8/0", inst_vld, free_cnt, iq_full);
    end
  endtask

  task automatic test_streaming();
    logic [31:0] sent[64];
    int          nout;
    int          acc;
    nout = 0;
    set_idle(); flush = 1; start_addr = 32'h8000; cycle(); flush = 0;
    for (int i = 0; i < 40; i++) begin
      if (i < 32) begin
        sent[2*i] = $urandom; sent[2*i+1] = $urandom;
        beat(32'h8000 + 32'(8 * i), {sent[2*i+1], sent[2*i]});
      end else begin
        data_vld = 0;
      end
      acc = model_acc_max();
      checks++;
      if (iq_full !== 1'b0) begin errors++; $display("FAIL stream_full cycle=%0d got=1 exp=0", i); end
      for (int j = 0; j < acc; j++) begin
        checks++;
        if (inst_addr[32*j +: 32] !== 32'h8000 + 32'(4 * nout) || inst[32*j +: 32] !== sent[nout]) begin
          errors++; $display("FAIL stream_order idx=%0d got=%h/%h exp=%h/%h", nout,
                             inst_addr[32*j +: 32], inst[32*j +: 32], 32'h8000 + 32'(4 * nout), sent[nout]);
        end
        nout++;
      end
      inst_acc = 2'(acc);
      cycle();
    end
    inst_acc = 0;
    checks++;
    if (nout !== 64) begin errors++; $display("FAIL stream_count got=%0d exp=64", nout); end
  endtask

  task automatic test_random();
    set_idle();
    for (int i = 0; i < 400; i++) begin
      reset      = ($urandom % 64) == 0;
      flush      = ($urandom % 16) == 0;
      start_addr = $urandom;
      data_vld   = ($urandom % 4) != 0;
      data_addr  = (($urandom % 4) == 0) ? ($urandom & ~32'h7) : m_exp;
      data       = {$urandom, $urandom};
      inst_acc   = 2'($urandom_range(0, model_acc_max()));
      cycle();
      checks++;
      if (dut_obs() !== model_obs()) begin
        errors++; $display("FAIL random_obs cycle=%0d got=%h exp=%h", i, dut_obs(), model_obs());
      end
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    m_exp = '0; m_skip = 0;
    test_reset();
    test_fill_drain();
    test_unaligned();
    test_stale();
    test_full_wrap();
    test_simultaneous();
    test_streaming();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
